// File: rtl/booth.sv
// -----------------------------------------------------------------------------
// booth -- sequential radix-2 Booth multiplier for signed operands.
//
// Multiplies two n-bit two's complement operands, retiring one multiplier bit
// per clock, and presents the 2n-bit signed product on a registered output.
//
// Parameters:
//   n      operand width in bits (n >= 2), default 8
//
// Ports:
//   op1    in   n    signed multiplicand, sampled on the accepting edge
//   op2    in   n    signed multiplier, sampled on the accepting edge
//   clk    in   1    clock, rising edge
//   start  in   1    begin a multiplication (honoured only in IDLE)
//   o      out  2n   signed product, held until the next completion
//   busy   out  1    high while a multiplication is in progress
//   rst_n  in   1    asynchronous active-low reset
//   done   out  1    (only with BOOTH_DONE_EN) one-cycle pulse after completion
//
// Build option:
//   BOOTH_DONE_EN  when defined, adds the done output and its register.
// -----------------------------------------------------------------------------
module booth #(
  parameter int n = 8
) (
  input  logic [n-1:0]   op1,
  input  logic [n-1:0]   op2,
  input  logic           clk,
  input  logic           start,
  output logic [2*n-1:0] o,
  output logic           busy,
  input  logic           rst_n
`ifdef BOOTH_DONE_EN
  ,
  output logic           done
`endif
);

  localparam int CW = (n > 1) ? $clog2(n) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_e;

  state_e          state_q;
  logic [n:0]      a_q;     // accumulator, one guard bit
  logic [n:0]      m_q;     // sign-extended multiplicand copy
  logic [n-1:0]    q_q;     // multiplier, shifted out LSB first
  logic            qm1_q;   // Q(-1), the bit shifted out last step
  logic [CW-1:0]   cnt_q;   // steps already performed
  logic [2*n-1:0]  o_q;
  logic            busy_q;
`ifdef BOOTH_DONE_EN
  logic            done_q;
`endif

  // Combinational Booth step: conditional add/subtract, then arithmetic shift.
  logic [n:0]      a_sum;
  logic [n:0]      a_d;
  logic [n-1:0]    q_d;
  logic            qm1_d;
  logic [2*n-1:0]  prod_d;
  logic            last_step;

  // NOTE: a_sum gets a default before the case so no path leaves it
  // unassigned; otherwise a latch would be inferred.
  always_comb begin
    a_sum = a_q;
    case ({q_q[0], qm1_q})
      2'b01:   a_sum = a_q + m_q;
      2'b10:   a_sum = a_q - m_q;
      default: a_sum = a_q;
    endcase
  end

  assign a_d       = {a_sum[n], a_sum[n:1]};
  assign q_d       = {a_sum[0], q_q[n-1:1]};
  assign qm1_d     = q_q[0];
  // {A,Q} is the exact product sign-extended to 2n+1 bits; the low 2n bits
  // are sufficient since |op1*op2| <= 2^(2n-2).
  assign prod_d    = {a_d[n-1:0], q_d};
  assign last_step = (cnt_q == CW'(n - 1));

  // NOTE: every register here uses non-blocking assignment so all state
  // updates on an edge see the values from before that edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      m_q     <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      o_q     <= '0;
      busy_q  <= 1'b0;
`ifdef BOOTH_DONE_EN
      done_q  <= 1'b0;
`endif
    end else begin
`ifdef BOOTH_DONE_EN
      done_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (start) begin
            m_q     <= {op1[n-1], op1};
            q_q     <= op2;
            a_q     <= '0;
            qm1_q   <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= CALC;
          end
        end
        CALC: begin
          a_q   <= a_d;
          q_q   <= q_d;
          qm1_q <= qm1_d;
          cnt_q <= cnt_q + CW'(1);
          // start is deliberately ignored here, including on the final step,
          // which guarantees one IDLE cycle between back-to-back operations.
          if (last_step) begin
            o_q     <= prod_d;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= IDLE;
`ifdef BOOTH_DONE_EN
            done_q  <= 1'b1;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o    = o_q;
  assign busy = busy_q;
`ifdef BOOTH_DONE_EN
  assign done = done_q;
`endif

endmodule

// File: tb/tb_booth.sv
// -----------------------------------------------------------------------------
// tb_booth -- self-checking bench for booth (n = 8).
//
// A transaction-level model predicts busy/o (and done when built with
// BOOTH_DONE_EN) each cycle from plain signed arithmetic; a compare process
// checks the DUT against it on every falling edge. Directed cases pin the
// model with hand-computed literals, then a randomized run with start held
// high exercises back-to-back operation.
// -----------------------------------------------------------------------------
module tb_booth;

  localparam int N      = 8;
  localparam int N_RAND = 2000;

  logic                  clk   = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  start = 1'b0;
  logic signed [N-1:0]   op1   = '0;
  logic signed [N-1:0]   op2   = '0;
  logic [2*N-1:0]        o;
  logic                  busy;
`ifdef BOOTH_DONE_EN
  logic                  done;
`endif

  int tests = 0;
  int fails = 0;

  booth #(.n(N)) dut (
    .op1   (op1),
    .op2   (op2),
    .clk   (clk),
    .start (start),
    .o     (o),
    .busy  (busy),
    .rst_n (rst_n)
`ifdef BOOTH_DONE_EN
    ,
    .done  (done)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: an accepted request captures op1*op2 and becomes visible
  // N edges later; requests are honoured only when not busy.
  // ---------------------------------------------------------------------------
  logic [2*N-1:0] exp_o      = '0;
  logic           exp_busy   = 1'b0;
  logic           exp_done   = 1'b0;
  logic [2*N-1:0] pend       = '0;
  int             remaining  = 0;
  int             accepted   = 0;
  int             completed  = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_o     = '0;
      exp_busy  = 1'b0;
      exp_done  = 1'b0;
      remaining = 0;
    end else begin
      exp_done = 1'b0;
      if (exp_busy) begin
        remaining--;
        if (remaining == 0) begin
          exp_o    = pend;
          exp_busy = 1'b0;
          exp_done = 1'b1;
          completed++;
        end
      end else if (start) begin
        int p;
        p         = int'(op1) * int'(op2);
        pend      = p[2*N-1:0];
        remaining = N;
        exp_busy  = 1'b1;
        accepted++;
      end
    end
  end

  logic check_en = 1'b0;

  always @(negedge clk) begin
    if (check_en) begin
      check("busy", 64'(busy), 64'(exp_busy));
      check("o", 64'(o), 64'(exp_o));
`ifdef BOOTH_DONE_EN
      check("done", 64'(done), 64'(exp_done));
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Directed helpers
  // ---------------------------------------------------------------------------
  // Single-cycle start pulse; optionally scramble operands right after the
  // accepting edge. Returns the number of cycles busy stayed high.
  task automatic run_op(input logic signed [N-1:0] a, input logic signed [N-1:0] b,
                        input bit scramble, output int busy_cycles);
    int guard;
    guard = 0;
    while (busy && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (busy) check("idle_before_start_timeout", 64'(busy), 64'd0);
    @(posedge clk); #1;
    op1   = a;
    op2   = b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (scramble) begin
      op1 = 8'sd100;
      op2 = 8'sd100;
    end
    busy_cycles = 0;
    while (busy && busy_cycles < 50) begin
      @(posedge clk); #1;
      busy_cycles++;
    end
    if (busy) check("op_timeout", 64'(busy), 64'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int cyc;
    int guard;

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_o", 64'(o), 64'd0);
    rst_n    = 1'b1;
    check_en = 1'b1;

    // 3 * 5, with latency check
    run_op(8'sd3, 8'sd5, 1'b0, cyc);
    check("lat_3x5", 64'(cyc), 64'd8);
    check("o_3x5", 64'(o), 64'h000F);

    run_op(-8'sd128, -8'sd128, 1'b0, cyc);
    check("o_m128xm128", 64'(o), 64'h4000);
    run_op(-8'sd128, 8'sd127, 1'b0, cyc);
    check("o_m128x127", 64'(o), 64'hC080);
    run_op(-8'sd1, -8'sd1, 1'b0, cyc);
    check("o_m1xm1", 64'(o), 64'h0001);
    run_op(8'sd0, -8'sd77, 1'b0, cyc);
    check("o_0xm77", 64'(o), 64'h0000);

    // Operand changes after acceptance must not matter
    run_op(8'sd7, 8'sd9, 1'b1, cyc);
    check("o_7x9_scrambled", 64'(o), 64'd63);

    // Abort mid-operation with reset
    @(posedge clk); #1;
    op1   = 8'sd55;
    op2   = -8'sd33;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("busy_before_abort", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_o", 64'(o), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_op(-8'sd6, 8'sd11, 1'b0, cyc);
    check("o_m6x11", 64'(o), 64'hFFBE);
    check("lat_m6x11", 64'(cyc), 64'd8);

    // Randomized back-to-back with start held high; operands churn every cycle
    accepted  = 0;
    completed = 0;
    @(posedge clk); #1;
    start = 1'b1;
    guard = 0;
    while (accepted < N_RAND && guard < N_RAND * 12) begin
      op1 = N'($urandom);
      op2 = N'($urandom);
      if (($urandom_range(0, 15)) == 0) op1 = -8'sd128;
      if (($urandom_range(0, 15)) == 0) op2 = -8'sd128;
      @(posedge clk); #1;
      guard++;
    end
    start = 1'b0;
    guard = 0;
    while (busy && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    check("rand_accepted", 64'(accepted), 64'(N_RAND));
    check("rand_completed", 64'(completed), 64'(N_RAND));
    check("rand_final_busy", 64'(busy), 64'd0);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
